mimo_8psk_tx_encoder: RTL and testbench



---
 rtl/mimo_8psk_tx_encoder.sv | 167 ++++++++++++++++
 tb/tb_mimo_8psk_tx_encoder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mimo_8psk_tx_encoder.sv
`default_nettype none
// ============================================================================
// mimo_8psk_tx_encoder : 4x4 8-PSK mapper and y = R*s former (R upper-tri).
// Optional macro GRAY_MAP_EN selects Gray-coded labels.   Revision: 1.0
// ============================================================================
module mimo_8psk_tx_encoder #(
  parameter int W_l  = 15,
  parameter int FRAC = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flagChannelorData,
  input  logic             ch_valid,
  output logic             ch_ready,
  input  logic [8*W_l-1:0] InData,
  output logic             h_loaded,
  input  logic             sym_valid,
  output logic             sym_ready,
  input  logic [11:0]      sym_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [8*W_l-1:0] OutData
);

  localparam int SW = 2*W_l + 3;
  localparam int C2_INT = $rtoi((2.0 ** FRAC) * 0.7071067811865476 + 0.5);
  localparam logic signed [W_l-1:0] c_c1  = W_l'(2 ** FRAC);
  localparam logic signed [W_l-1:0] c_c2  = W_l'(C2_INT);
  localparam logic signed [W_l-1:0] c_pos = {1'b0, {(W_l-1){1'b1}}};
  localparam logic signed [W_l-1:0] c_neg = {1'b1, {(W_l-1){1'b0}}};
  localparam logic signed [SW-1:0]  c_max  = SW'(c_pos);
  localparam logic signed [SW-1:0]  c_min  = SW'(c_neg);
  localparam logic signed [SW-1:0]  c_half = SW'(2 ** (FRAC-1));

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_calc = 2'd1;
  localparam logic [1:0] c_st_hold = 2'd2;

  logic [1:0]             r_state, w_state_nxt;
  logic [1:0]             r_row, r_beat;
  logic                   r_h_loaded;
  logic [11:0]            r_labels;
  logic signed [W_l-1:0]  r_re [4][4];
  logic signed [W_l-1:0]  r_im [4][4];
  logic [8*W_l-1:0]       r_out;
  logic                   w_ch_acc, w_sym_acc;
  logic signed [W_l-1:0]  w_sre [4];
  logic signed [W_l-1:0]  w_sim [4];
  logic signed [2*W_l-1:0] w_prr [4];
  logic signed [2*W_l-1:0] w_pii [4];
  logic signed [2*W_l-1:0] w_pri [4];
  logic signed [2*W_l-1:0] w_pir [4];
  logic signed [SW-1:0]   w_acc_re, w_acc_im;
  logic signed [W_l-1:0]  w_yre, w_yim;

  function automatic logic signed [W_l-1:0] round_sat(input logic signed [SW-1:0] acc);
    logic signed [SW-1:0] r;
    r = (acc + c_half) >>> FRAC;
    if (r > c_max)      round_sat = c_pos;
    else if (r < c_min) round_sat = c_neg;
    else                round_sat = r[W_l-1:0];
  endfunction

  for (genvar gi = 0; gi < 4; gi++) begin : g_map
    logic [2:0] w_lab, w_p;
    assign w_lab = r_labels[3*gi +: 3];
`ifdef GRAY_MAP_EN
    assign w_p = {w_lab[2], w_lab[2] ^ w_lab[1], w_lab[2] ^ w_lab[1] ^ w_lab[0]};
`else
    assign w_p = w_lab;
`endif
    always_comb begin
      w_sre[gi] = '0;
      w_sim[gi] = '0;
      case (w_p)
        3'd0: begin w_sre[gi] =  c_c1; w_sim[gi] =  '0;   end
        3'd1: begin w_sre[gi] =  c_c2; w_sim[gi] =  c_c2; end
        3'd2: begin w_sre[gi] =  '0;   w_sim[gi] =  c_c1; end
        3'd3: begin w_sre[gi] = -c_c2; w_sim[gi] =  c_c2; end
        3'd4: begin w_sre[gi] = -c_c1; w_sim[gi] =  '0;   end
        3'd5: begin w_sre[gi] = -c_c2; w_sim[gi] = -c_c2; end
        3'd6: begin w_sre[gi] =  '0;   w_sim[gi] = -c_c1; end
        default: begin w_sre[gi] = c_c2; w_sim[gi] = -c_c2; end
      endcase
    end
  end

  // One full row of the complex inner product per CALC cycle, exact until rounding.
  always_comb begin
    w_acc_re = '0;
    w_acc_im = '0;
    for (int j = 0; j < 4; j++) begin
      w_prr[j] = r_re[r_row][j] * w_sre[j];
      w_pii[j] = r_im[r_row][j] * w_sim[j];
      w_pri[j] = r_re[r_row][j] * w_sim[j];
      w_pir[j] = r_im[r_row][j] * w_sre[j];
      if (j >= int'(r_row)) begin
        w_acc_re = w_acc_re + SW'(w_prr[j]) - SW'(w_pii[j]);
        w_acc_im = w_acc_im + SW'(w_pri[j]) + SW'(w_pir[j]);
      end
    end
    w_yre = round_sat(w_acc_re);
    w_yim = round_sat(w_acc_im);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (w_sym_acc) w_state_nxt = c_st_calc;
      c_st_calc: if (r_row == 2'd3) w_state_nxt = c_st_hold;
      c_st_hold: if (out_ready) w_state_nxt = c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    ch_ready  = rst && (r_state == c_st_idle);
    sym_ready = rst && (r_state == c_st_idle) && r_h_loaded && !flagChannelorData;
    out_valid = (r_state == c_st_hold);
    w_ch_acc  = ch_valid && ch_ready && flagChannelorData;
    w_sym_acc = sym_valid && sym_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row      <= '0;
      r_beat     <= '0;
      r_h_loaded <= 1'b0;
      r_labels   <= '0;
      r_out      <= '0;
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 4; j++) begin
          r_re[k][j] <= '0;
          r_im[k][j] <= '0;
        end
    end else begin
      if (w_ch_acc) begin
        for (int j = 0; j < 4; j++) begin
          r_re[r_beat][j] <= (j < int'(r_beat)) ? '0 : InData[j*W_l +: W_l];
          r_im[r_beat][j] <= (j < int'(r_beat)) ? '0 : InData[(4+j)*W_l +: W_l];
        end
        r_beat <= r_beat + 2'd1;
        if (r_beat == 2'd0) r_h_loaded <= 1'b0;
        if (r_beat == 2'd3) r_h_loaded <= 1'b1;
      end
      if (w_sym_acc) begin
        r_labels <= sym_in;
        r_row    <= '0;
      end
      if (r_state == c_st_calc) begin
        r_out[2*int'(r_row)*W_l +: W_l]     <= w_yre;
        r_out[(2*int'(r_row)+1)*W_l +: W_l] <= w_yim;
        r_row <= r_row + 2'd1;
      end
    end
  end

  assign h_loaded = r_h_loaded;
  assign OutData  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mimo_8psk_tx_encoder.sv
`default_nettype none
// ============================================================================
// tb_mimo_8psk_tx_encoder : scoreboard bench for mimo_8psk_tx_encoder.
// Revision: 1.0
// ============================================================================
module tb_mimo_8psk_tx_encoder;
  localparam int W = 15;
  localparam int FRAC = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           flag = 1'b0, ch_valid = 1'b0, sym_valid = 1'b0, out_ready = 1'b0;
  logic [8*W-1:0] InData = '0;
  logic [11:0]    sym_in = '0;
  logic           ch_ready, h_loaded, sym_ready, out_valid;
  logic [8*W-1:0] OutData;

  int n_vec = 0;
  int n_err = 0;
  logic [8*W-1:0] sb_q[$];
  longint ld_re[4][4], ld_im[4][4], m_re[4][4], m_im[4][4];

  mimo_8psk_tx_encoder #(.W_l(W), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .flagChannelorData(flag), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .InData(InData), .h_loaded(h_loaded),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_in(sym_in),
    .out_valid(out_valid), .out_ready(out_ready), .OutData(OutData)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sat(input longint a);
    longint r;
    r = (a + 512) >>> FRAC;
    if (r > 16383)  r = 16383;
    if (r < -16384) r = -16384;
    return r[W-1:0];
  endfunction

  function automatic logic [8*W-1:0] model_y(input logic [11:0] lab);
    longint pre[8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
    longint pim[8] = '{0, 724, 1024, 724, 0, -724, -1024, -724};
    longint sre[4], sim[4], are, aim;
    logic [2:0] b, p;
    logic [8*W-1:0] res;
    for (int i = 0; i < 4; i++) begin
      b = lab[3*i +: 3];
`ifdef GRAY_MAP_EN
      p = {b[2], b[2] ^ b[1], b[2] ^ b[1] ^ b[0]};
`else
      p = b;
`endif
      sre[i] = pre[p];
      sim[i] = pim[p];
    end
    for (int i = 0; i < 4; i++) begin
      are = 0;
      aim = 0;
      for (int j = i; j < 4; j++) begin
        are += m_re[i][j] * sre[j] - m_im[i][j] * sim[j];
        aim += m_re[i][j] * sim[j] + m_im[i][j] * sre[j];
      end
      res[2*i*W +: W]     = sat(are);
      res[(2*i+1)*W +: W] = sat(aim);
    end
    return res;
  endfunction

  task automatic clear_ld();
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        ld_re[k][j] = 0;
        ld_im[k][j] = 0;
      end
  endtask

  task automatic load_r();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("ch_ready_idle", ch_ready, 1'b1);
      flag = 1'b1;
      ch_valid = 1'b1;
      for (int j = 0; j < 4; j++) begin
        InData[j*W +: W]     = W'(ld_re[k][j]);
        InData[(4+j)*W +: W] = W'(ld_im[k][j]);
        m_re[k][j] = (j < k) ? 0 : ld_re[k][j];
        m_im[k][j] = (j < k) ? 0 : ld_im[k][j];
      end
      @(posedge clk);
      #1;
      if (k == 0) check_eq("h_loaded_clr", h_loaded, 1'b0);
      if (k == 3) check_eq("h_loaded_set", h_loaded, 1'b1);
    end
    @(negedge clk);
    ch_valid = 1'b0;
    flag = 1'b0;
  endtask

  task automatic run_vec(input logic [11:0] lab, input int hold);
    logic [8*W-1:0] exp;
    int cyc;
    @(negedge clk);
    check_eq("sym_ready", sym_ready, 1'b1);
    sym_valid = 1'b1;
    sym_in = lab;
    sb_q.push_back(model_y(lab));
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_eq("latency", cyc, 4);
    exp = sb_q.pop_front();
    check_eq("outdata", OutData, exp);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk);
      #1;
      check_eq("hold_data", OutData, exp);
      check_eq("hold_valid", out_valid, 1'b1);
      check_eq("hold_sym_ready", sym_ready, 1'b0);
      check_eq("hold_ch_ready", ch_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("valid_drop", out_valid, 1'b0);
    check_eq("data_kept", OutData, exp);
    check_eq("back_idle", ch_ready, 1'b1);
  endtask

  task automatic set_diag(input longint v);
    clear_ld();
    for (int k = 0; k < 4; k++) ld_re[k][k] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8*W-1:0] tmp;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        m_re[k][j] = 0;
        m_im[k][j] = 0;
      end
    #12;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_outdata", OutData, '0);
    check_eq("rst_h_loaded", h_loaded, 1'b0);
    check_eq("rst_ch_ready", ch_ready, 1'b0);
    check_eq("rst_sym_ready", sym_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Identity channel, several label patterns.
    set_diag(1024);
    load_r();
    run_vec(12'h000, 0);
    check_eq("diag_y0_re", OutData[W-1:0], 15'd1024);
    check_eq("diag_y3_im", OutData[7*W +: W], 15'd0);
    run_vec(12'h001, 0);
    check_eq("s0p1_re", OutData[W-1:0], 15'd724);
    check_eq("s0p1_im", OutData[W +: W], 15'd724);
    run_vec(12'h002, 0);
`ifdef GRAY_MAP_EN
    check_eq("lab2_re", OutData[W-1:0], W'(-724));
    check_eq("lab2_im", OutData[W +: W], 15'd724);
`else
    check_eq("lab2_re", OutData[W-1:0], 15'd0);
    check_eq("lab2_im", OutData[W +: W], 15'd1024);
`endif
    run_vec(12'hFAC, 10);

    // Saturation of row 0 in both directions.
    clear_ld();
    for (int j = 0; j < 4; j++) ld_re[0][j] = 16383;
    load_r();
    run_vec(12'h000, 0);
    check_eq("sat_pos", OutData[W-1:0], 15'h3FFF);
    clear_ld();
    for (int j = 0; j < 4; j++) ld_re[0][j] = -16384;
    load_r();
    run_vec(12'h000, 0);
    check_eq("sat_neg", OutData[W-1:0], 15'h4000);

    // Random channels and labels.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 4; j++) begin
          ld_re[k][j] = longint'($urandom_range(0, 32767)) - 16384;
          ld_im[k][j] = longint'($urandom_range(0, 32767)) - 16384;
        end
      load_r();
      run_vec(12'($urandom_range(0, 4095)), 0);
      run_vec(12'($urandom_range(0, 4095)), 0);
    end

    // Reset asserted while CALC is on row 2.
    set_diag(1024);
    load_r();
    @(negedge clk);
    sym_valid = 1'b1;
    sym_in = 12'h000;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    tmp = model_y(12'h000);
    check_eq("pre_rst_y0", OutData[2*W-1:0], tmp[2*W-1:0]);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_data", OutData, '0);
    check_eq("mid_rst_h_loaded", h_loaded, 1'b0);
    check_eq("mid_rst_ch_ready", ch_ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    sym_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check_eq("post_rst_sym_ready", sym_ready, 1'b0);
      check_eq("post_rst_valid", out_valid, 1'b0);
    end
    @(negedge clk);
    sym_valid = 1'b0;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) begin
        m_re[k][j] = 0;
        m_im[k][j] = 0;
      end
    load_r();
    run_vec(12'h249, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
